// File: rtl/rs_pkg.sv
// Shared constants for the RS latch writer: FSM state encoding, default
// timing and the width of the shared cycle timer.
package rs_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_PULSE  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;

  localparam int unsigned DEF_PULSE_CYCLES  = 2;
  localparam int unsigned DEF_SETTLE_CYCLES = 1;
  localparam int unsigned DEF_CNT_W         = 8;
  localparam int unsigned TIMER_W           = 4;

  // The timer holds a phase for load+1 cycles, so an N-cycle phase loads N-1.
  function automatic logic [TIMER_W-1:0] timer_load(input int unsigned cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/rs_cycle_timer.sv
// Loadable down-counter with zero flag; times both the PULSE and the SETTLE
// phases of a latch write.
module rs_cycle_timer
  import rs_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rs_latch_writer.sv
// Initiator for a gated RS latch cell: turns valid/ready bit writes into
// R/S/gate pulses and verifies Q/NQ. Optional macro: RS_SKIP_REDUNDANT_EN.
module rs_latch_writer
  import rs_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = DEF_PULSE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             C,
  input  logic             RST,
  input  logic             D,
  input  logic             VALID,
  output logic             READY,
  output logic             R_OUT,
  output logic             S_OUT,
  output logic             G_OUT,
  input  logic             Q_IN,
  input  logic             NQ_IN,
  output logic             DONE,
  output logic             ERR,
  output logic [CNT_W-1:0] WR_COUNT
);

  logic [2:0]         state_q, state_d;
  logic               bit_q, bit_d;
  logic               r_q, r_d;
  logic               s_q, s_d;
  logic               g_q, g_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_zero;

  rs_cycle_timer u_timer (
    .clk_i      (C),
    .rst_i      (RST),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // NOTE: every next-state signal is defaulted to its current value before the
  // case statement, so no path through this block can infer a latch.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    r_d      = r_q;
    s_d      = s_q;
    g_d      = g_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (VALID) begin
          bit_d = D;
`ifdef RS_SKIP_REDUNDANT_EN
          if ((Q_IN == D) && (Q_IN != NQ_IN)) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_SETUP;
            s_d     = D;
            r_d     = ~D;
          end
`else
          state_d = ST_SETUP;
          s_d     = D;
          r_d     = ~D;
`endif
        end
      end
      ST_SETUP: begin
        state_d  = ST_PULSE;
        g_d      = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = timer_load(PULSE_CYCLES);
      end
      ST_PULSE: begin
        // Gate and both commands drop together so R/S never change under an open gate.
        if (tmr_zero) begin
          state_d  = ST_SETTLE;
          g_d      = 1'b0;
          r_d      = 1'b0;
          s_d      = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = timer_load(SETTLE_CYCLES);
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if ((Q_IN != bit_q) || (Q_IN == NQ_IN)) begin
          err_d = 1'b1;
        end
        cnt_d   = cnt_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        r_d     = 1'b0;
        s_d     = 1'b0;
        g_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (RST) begin
      state_q <= ST_IDLE;
      bit_q   <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      g_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      r_q     <= r_d;
      s_q     <= s_d;
      g_q     <= g_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign READY    = (state_q == ST_IDLE);
  assign DONE     = (state_q == ST_CHECK);
  assign R_OUT    = r_q;
  assign S_OUT    = s_q;
  assign G_OUT    = g_q;
  assign ERR      = err_q;
  assign WR_COUNT = cnt_q;

endmodule

// File: tb/tb_rs_latch_writer.sv
// Self-checking bench for rs_latch_writer driving a behavioural gated RS latch,
// with directed and randomized writes checked against a transaction-level model.
module tb_rs_latch_writer;

  localparam int P   = 2;
  localparam int S   = 1;
  localparam int CW  = 8;
  localparam int LAT = 1 + P + S + 1;

  logic          C = 1'b0;
  logic          RST;
  logic          D;
  logic          VALID;
  logic          READY;
  logic          R_OUT;
  logic          S_OUT;
  logic          G_OUT;
  logic          Q_IN;
  logic          NQ_IN;
  logic          DONE;
  logic          ERR;
  logic [CW-1:0] WR_COUNT;

  logic lat_q    = 1'b0;
  logic fault_en = 1'b0;

  int tests = 0;
  int fails = 0;

  int  exp_cnt = 0;
  bit  exp_err = 1'b0;

  rs_latch_writer #(
    .PULSE_CYCLES  (P),
    .SETTLE_CYCLES (S),
    .CNT_W         (CW)
  ) dut (
    .C        (C),
    .RST      (RST),
    .D        (D),
    .VALID    (VALID),
    .READY    (READY),
    .R_OUT    (R_OUT),
    .S_OUT    (S_OUT),
    .G_OUT    (G_OUT),
    .Q_IN     (Q_IN),
    .NQ_IN    (NQ_IN),
    .DONE     (DONE),
    .ERR      (ERR),
    .WR_COUNT (WR_COUNT)
  );

  always #5 C = ~C;

  // Gated RS latch load: transparent while the gate is high, inputs are
  // registered by the DUT so a mid-cycle update is equivalent.
  always @(negedge C) begin
    if (G_OUT) begin
      if (S_OUT && !R_OUT) lat_q <= 1'b1;
      else if (R_OUT && !S_OUT) lat_q <= 1'b0;
    end
  end

  assign Q_IN  = fault_en ? 1'b1 : lat_q;
  assign NQ_IN = fault_en ? 1'b1 : ~lat_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One write transaction, starting and ending on a negedge with the DUT idle.
  task automatic write_req(input logic d, input bit fault, input bit poke);
    int  g_n, s_n, r_n, done_n, done_at;
    bit  skip;
    g_n = 0; s_n = 0; r_n = 0; done_n = 0; done_at = 0;
    skip = 1'b0;
`ifdef RS_SKIP_REDUNDANT_EN
    skip = (Q_IN == d) && (Q_IN != NQ_IN);
`endif
    check("ready_before", READY, 1);
    D     = d;
    VALID = 1'b1;
    @(negedge C);
    VALID = 1'b0;
    for (int t = 1; t <= LAT + 2; t++) begin
      fault_en = 1'b0;
      g_n += int'(G_OUT);
      s_n += int'(S_OUT);
      r_n += int'(R_OUT);
      check("rs_exclusive", R_OUT & S_OUT, 0);
      if (DONE) begin
        done_n++;
        if (done_at == 0) done_at = t;
        if (fault) fault_en = 1'b1;
      end
      if (poke && !skip && t == 2) begin
        VALID = 1'b1;
        D     = ~d;
      end else begin
        VALID = 1'b0;
      end
      @(negedge C);
    end
    fault_en = 1'b0;
    VALID    = 1'b0;

    exp_cnt = (exp_cnt + 1) % (1 << CW);
    if (fault) exp_err = 1'b1;

    check("done_count", done_n, 1);
    check("done_latency", done_at, skip ? 1 : LAT);
    check("gate_cycles", g_n, skip ? 0 : P);
    check("set_cycles", s_n, (d && !skip) ? 1 + P : 0);
    check("reset_cycles", r_n, (!d && !skip) ? 1 + P : 0);
    check("latch_value", lat_q, d);
    check("wr_count", WR_COUNT, exp_cnt);
    check("err", ERR, exp_err);
    check("ready_after", READY, 1);
  endtask

  task automatic reset_mid_pulse();
    int  waited;
    bit  saw_g;
    int  done_n;
    waited = 0;
    saw_g  = 1'b0;
    D      = ~lat_q;
    VALID  = 1'b1;
    @(negedge C);
    VALID = 1'b0;
    while (!saw_g && waited < 6) begin
      if (G_OUT) saw_g = 1'b1;
      else begin
        @(negedge C);
        waited++;
      end
    end
    check("mid_gate_seen", saw_g, 1);
    RST = 1'b1;
    @(negedge C);
    RST     = 1'b0;
    exp_cnt = 0;
    exp_err = 1'b0;
    check("mid_rst_gate", G_OUT, 0);
    check("mid_rst_ready", READY, 1);
    check("mid_rst_rs", {R_OUT, S_OUT}, 0);
    check("mid_rst_count", WR_COUNT, 0);
    check("mid_rst_err", ERR, 0);
    done_n = 0;
    for (int t = 0; t < LAT + 2; t++) begin
      done_n += int'(DONE);
      @(negedge C);
    end
    check("mid_rst_no_done", done_n, 0);
    check("mid_rst_count_hold", WR_COUNT, 0);
  endtask

  initial begin
    RST   = 1'b1;
    VALID = 1'b0;
    D     = 1'b0;
    repeat (2) @(negedge C);
    check("rst_r", R_OUT, 0);
    check("rst_s", S_OUT, 0);
    check("rst_g", G_OUT, 0);
    check("rst_ready", READY, 1);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    check("rst_count", WR_COUNT, 0);
    RST = 1'b0;
    @(negedge C);

    write_req(1'b1, 1'b0, 1'b0);
    write_req(1'b0, 1'b0, 1'b0);
    write_req(1'b1, 1'b0, 1'b1);
    write_req(1'b1, 1'b1, 1'b0);
    write_req(1'b0, 1'b0, 1'b0);
    write_req(1'b1, 1'b0, 1'b0);

    reset_mid_pulse();
    write_req(lat_q, 1'b0, 1'b0);
    write_req(lat_q, 1'b0, 1'b0);

    for (int n = 0; n < 270; n++) begin
      write_req(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 2)) @(negedge C);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
